// File: rtl/usb_rx_timer.sv
// USB full-speed RX bit timer: recovers 12 Mb/s bit timing (8/8/9-cycle periods) from clk.
// Optional build macro USB_RX_RESYNC_EN realigns the bit phase on every d_edge in RUN.
module usb_rx_timer #(
  parameter int unsigned SAMPLE_PT     = 3,
  parameter int unsigned BITS_PER_BYTE = 8
) (
  input  logic       clk,
  input  logic       n_rst,
  input  logic       rcving,
  input  logic       d_edge,
  input  logic       stuff_bit,
  output logic       sample_tick,
  output logic       shift_enable,
  output logic [3:0] bit_cnt,
  output logic       byte_almost_received,
  output logic       byte_received
);

  localparam int unsigned PH_W  = 4;
  localparam int unsigned IDX_W = 2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARM  = 2'd1,
    RUN  = 2'd2
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [PH_W-1:0]    phase_cnt;
  logic [PH_W-1:0]    phase_nxt;
  logic [PH_W-1:0]    phase_last;
  logic [IDX_W-1:0]   period_idx;
  logic [IDX_W-1:0]   period_nxt;
  logic [CNT_W-1:0]   bit_cnt_nxt;
  logic               byte_received_nxt;
  logic               resync;

`ifdef USB_RX_RESYNC_EN
  assign resync = d_edge;
`else
  assign resync = 1'b0;
`endif

  // State and counter registers
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state         <= IDLE;
      phase_cnt     <= '0;
      period_idx    <= '0;
      bit_cnt       <= '0;
      byte_received <= 1'b0;
    end else begin
      state         <= state_nxt;
      phase_cnt     <= phase_nxt;
      period_idx    <= period_nxt;
      bit_cnt       <= bit_cnt_nxt;
      byte_received <= byte_received_nxt;
    end
  end

  // Next-state, counter update and strobe decode
  always_comb begin
    state_nxt            = state;
    phase_nxt            = phase_cnt;
    period_nxt           = period_idx;
    bit_cnt_nxt          = bit_cnt;
    byte_received_nxt    = 1'b0;
    sample_tick          = 1'b0;
    shift_enable         = 1'b0;
    byte_almost_received = 1'b0;
    phase_last           = (period_idx == IDX_W'(2)) ? PH_W'(8) : PH_W'(7);

    case (state)
      IDLE: begin
        phase_nxt   = '0;
        period_nxt  = '0;
        bit_cnt_nxt = '0;
        if (rcving) state_nxt = ARM;
      end

      ARM: begin
        phase_nxt   = '0;
        period_nxt  = '0;
        bit_cnt_nxt = '0;
        if (!rcving)     state_nxt = IDLE;
        else if (d_edge) state_nxt = RUN;
      end

      RUN: begin
        sample_tick          = (phase_cnt == PH_W'(SAMPLE_PT));
        shift_enable         = sample_tick && !stuff_bit;
        byte_almost_received = (bit_cnt == CNT_W'(BITS_PER_BYTE - 1));
        if (!rcving) begin
          // Abort discards the partial byte
          state_nxt   = IDLE;
          phase_nxt   = '0;
          period_nxt  = '0;
          bit_cnt_nxt = '0;
        end else begin
          if (resync) begin
            phase_nxt = '0;
          end else if (phase_cnt == phase_last) begin
            phase_nxt  = '0;
            period_nxt = (period_idx == IDX_W'(2)) ? '0 : period_idx + IDX_W'(1);
          end else begin
            phase_nxt = phase_cnt + PH_W'(1);
          end

          if (shift_enable) begin
            if (byte_almost_received) begin
              bit_cnt_nxt       = '0;
              byte_received_nxt = 1'b1;
            end else begin
              bit_cnt_nxt = bit_cnt + CNT_W'(1);
            end
          end
        end
      end

      default: begin
        state_nxt   = IDLE;
        phase_nxt   = '0;
        period_nxt  = '0;
        bit_cnt_nxt = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_usb_rx_timer.sv
// Self-checking bench for usb_rx_timer: table-driven timelines plus directed corner sequences.
module tb_usb_rx_timer;

  logic       clk;
  logic       n_rst;
  logic       rcving;
  logic       d_edge;
  logic       stuff_bit;
  logic       sample_tick;
  logic       shift_enable;
  logic [3:0] bit_cnt;
  logic       byte_almost_received;
  logic       byte_received;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  usb_rx_timer #(.SAMPLE_PT(3), .BITS_PER_BYTE(8)) dut (
    .clk                  (clk),
    .n_rst                (n_rst),
    .rcving               (rcving),
    .d_edge               (d_edge),
    .stuff_bit            (stuff_bit),
    .sample_tick          (sample_tick),
    .shift_enable         (shift_enable),
    .bit_cnt              (bit_cnt),
    .byte_almost_received (byte_almost_received),
    .byte_received        (byte_received)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int         seq;
    int         cyc;
    logic       r;
    logic       e;
    logic       s;
    logic       tick;
    logic       shift;
    logic [3:0] bcnt;
    logic       almost;
    logic       brx;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s (cycle %0d): got %0h expected %0h", name, cyc, act, exp_v);
    end
  endtask

  task automatic check_all(input string name, input logic t, input logic sh,
                           input logic [3:0] bc, input logic al, input logic br);
    chk({name, "_tick"},   8'(sample_tick),          8'(t));
    chk({name, "_shift"},  8'(shift_enable),         8'(sh));
    chk({name, "_bitcnt"}, 8'(bit_cnt),              8'(bc));
    chk({name, "_almost"}, 8'(byte_almost_received), 8'(al));
    chk({name, "_byterx"}, 8'(byte_received),        8'(br));
  endtask

  // Drive one cycle's inputs after the falling edge; outputs are checked 1ns later
  task automatic cycle_in(input logic r, input logic e, input logic s);
    @(negedge clk);
    rcving = r; d_edge = e; stuff_bit = s;
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0; rcving = 1'b0; d_edge = 1'b0; stuff_bit = 1'b0;
    repeat (2) @(negedge clk);
    n_rst = 1'b1;
    cyc = -1;
  endtask

  task automatic run_seq(input int id);
    int last;
    last = 0;
    foreach (vecs[i]) if (vecs[i].seq == id && vecs[i].cyc > last) last = vecs[i].cyc;
    do_reset();
    for (int c = 0; c <= last; c++) begin
      int hit;
      hit = -1;
      foreach (vecs[i]) if (vecs[i].seq == id && vecs[i].cyc == c) hit = i;
      if (hit >= 0) begin
        cycle_in(vecs[hit].r, vecs[hit].e, vecs[hit].s);
        check_all($sformatf("seq%0d_c%0d", id, c), vecs[hit].tick, vecs[hit].shift,
                  vecs[hit].bcnt, vecs[hit].almost, vecs[hit].brx);
      end else begin
        cycle_in(1'b1, 1'b0, 1'b0);
      end
    end
  endtask

  // IDLE -> ARM -> aligning edge; on return the next cycle_in is RUN phase 0
  task automatic start_run();
    do_reset();
    cycle_in(1'b1, 1'b0, 1'b0);
    cycle_in(1'b1, 1'b1, 1'b0);
  endtask

  // Returns the 1-based index of the first cycle with a tick, 0 if none within maxc
  task automatic find_tick(input int maxc, output int n);
    n = 0;
    for (int i = 1; i <= maxc; i++) begin
      if (n == 0) begin
        cycle_in(1'b1, 1'b0, 1'b0);
        if (sample_tick) n = i;
      end
    end
  endtask

  initial begin
    int n;
    int exp_n;
    int guard;
    n_rst = 1'b0; rcving = 1'b0; d_edge = 1'b0; stuff_bit = 1'b0;

    // seq 1: basic 8/8/9 timing, edge at cycle 10, byte after 8th tick
    vecs.push_back('{1,  0, 1,0,0, 0,0,4'd0,0,0});
    vecs.push_back('{1,  5, 1,0,0, 0,0,4'd0,0,0});
    vecs.push_back('{1, 10, 1,1,0, 0,0,4'd0,0,0});
    vecs.push_back('{1, 11, 1,0,0, 0,0,4'd0,0,0});
    vecs.push_back('{1, 13, 1,0,0, 0,0,4'd0,0,0});
    vecs.push_back('{1, 14, 1,0,0, 1,1,4'd0,0,0});
    vecs.push_back('{1, 15, 1,0,0, 0,0,4'd1,0,0});
    vecs.push_back('{1, 22, 1,0,0, 1,1,4'd1,0,0});
    vecs.push_back('{1, 23, 1,0,0, 0,0,4'd2,0,0});
    vecs.push_back('{1, 30, 1,0,0, 1,1,4'd2,0,0});
    vecs.push_back('{1, 31, 1,0,0, 0,0,4'd3,0,0});
    vecs.push_back('{1, 38, 1,0,0, 0,0,4'd3,0,0});
    vecs.push_back('{1, 39, 1,0,0, 1,1,4'd3,0,0});
    vecs.push_back('{1, 47, 1,0,0, 1,1,4'd4,0,0});
    vecs.push_back('{1, 55, 1,0,0, 1,1,4'd5,0,0});
    vecs.push_back('{1, 63, 1,0,0, 0,0,4'd6,0,0});
    vecs.push_back('{1, 64, 1,0,0, 1,1,4'd6,0,0});
    vecs.push_back('{1, 65, 1,0,0, 0,0,4'd7,1,0});
    vecs.push_back('{1, 72, 1,0,0, 1,1,4'd7,1,0});
    vecs.push_back('{1, 73, 1,0,0, 0,0,4'd0,0,1});
    vecs.push_back('{1, 74, 1,0,0, 0,0,4'd0,0,0});
    vecs.push_back('{1, 80, 1,0,0, 1,1,4'd0,0,0});
    // seq 2: stuffed 4th bit, byte completes on the 9th tick
    vecs.push_back('{2, 10, 1,1,0, 0,0,4'd0,0,0});
    vecs.push_back('{2, 14, 1,0,0, 1,1,4'd0,0,0});
    vecs.push_back('{2, 39, 1,0,1, 1,0,4'd3,0,0});
    vecs.push_back('{2, 40, 1,0,0, 0,0,4'd3,0,0});
    vecs.push_back('{2, 47, 1,0,0, 1,1,4'd3,0,0});
    vecs.push_back('{2, 55, 1,0,0, 1,1,4'd4,0,0});
    vecs.push_back('{2, 64, 1,0,0, 1,1,4'd5,0,0});
    vecs.push_back('{2, 72, 1,0,0, 1,1,4'd6,0,0});
    vecs.push_back('{2, 73, 1,0,0, 0,0,4'd7,1,0});
    vecs.push_back('{2, 80, 1,0,0, 1,1,4'd7,1,0});
    vecs.push_back('{2, 81, 1,0,0, 0,0,4'd0,0,1});
    vecs.push_back('{2, 82, 1,0,0, 0,0,4'd0,0,0});

    // Reset held, then idle with random edges: everything stays quiet
    for (int i = 0; i < 2; i++) begin
      cycle_in(1'b0, 1'($urandom_range(0, 1)), 1'b0);
      check_all("in_reset", 0, 0, 4'd0, 0, 0);
    end
    @(negedge clk); n_rst = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle_in(1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check_all("idle", 0, 0, 4'd0, 0, 0);
    end

    run_seq(1);
    run_seq(2);

    // Resync: edge two cycles after a tick
    start_run();
    find_tick(12, n);
    chk("resync_first_tick", 8'(n), 8'd4);
    cycle_in(1'b1, 1'b0, 1'b0);
    cycle_in(1'b1, 1'b1, 1'b0);
    chk("resync_edge_no_tick", 8'(sample_tick), 8'd0);
    find_tick(12, n);
`ifdef USB_RX_RESYNC_EN
    exp_n = 4;
`else
    exp_n = 6;
`endif
    chk("resync_next_tick", 8'(n), 8'(exp_n));

    // Edge coincident with the sample point
    start_run();
    for (int i = 0; i < 3; i++) cycle_in(1'b1, 1'b0, 1'b0);
    cycle_in(1'b1, 1'b1, 1'b0);
    chk("coinc_tick_issued", 8'(sample_tick), 8'd1);
    chk("coinc_shift",       8'(shift_enable), 8'd1);
    find_tick(12, n);
`ifdef USB_RX_RESYNC_EN
    exp_n = 4;
`else
    exp_n = 8;
`endif
    chk("coinc_next_tick", 8'(n), 8'(exp_n));

    // Abort mid-byte at bit_cnt 5
    start_run();
    guard = 0;
    while (bit_cnt != 4'd5 && guard < 100) begin
      cycle_in(1'b1, 1'b0, 1'b0);
      guard++;
    end
    chk("abort_reached_bit5", 8'(bit_cnt), 8'd5);
    cycle_in(1'b0, 1'b0, 1'b0);
    cycle_in(1'b0, 1'b0, 1'b0);
    check_all("abort_idle", 0, 0, 4'd0, 0, 0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle_in(1'b0, 1'b0, 1'b0);
      if (sample_tick || byte_received || bit_cnt != 4'd0) n++;
    end
    chk("abort_quiet_idle", 8'(n), 8'd0);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      cycle_in(1'b1, 1'b0, 1'b0);
      if (sample_tick || byte_received) n++;
    end
    chk("abort_quiet_arm", 8'(n), 8'd0);
    cycle_in(1'b1, 1'b1, 1'b0);
    find_tick(12, n);
    chk("abort_rearm_tick", 8'(n), 8'd4);
    chk("abort_rearm_bitcnt", 8'(bit_cnt), 8'd0);

    // Asynchronous reset mid-byte clears without a clock edge
    find_tick(12, n);
    find_tick(12, n);
    chk("areset_pre_bitcnt", 8'(bit_cnt), 8'd2);
    #2 n_rst = 1'b0;
    #1;
    chk("areset_bitcnt", 8'(bit_cnt), 8'd0);
    chk("areset_byterx", 8'(byte_received), 8'd0);
    @(negedge clk); n_rst = 1'b1; rcving = 1'b0;
    cycle_in(1'b1, 1'b0, 1'b0);
    check_all("areset_after", 0, 0, 4'd0, 0, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
